// File: rtl/alu_sched_if.sv
// Request/response bundle for the two ports of the shared-ALU scheduler.
// Latency: none, wires only.
// Backpressure: valid/ready on the request and response channels of each port.
interface alu_sched_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [3:0]  req0_sel;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_data;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [3:0]  req1_sel;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_data;

    // Scheduler side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel, rsp0_ready,
        input  req1_valid, req1_a, req1_b, req1_sel, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data
    );

    // Requester side
    modport master (
        output req0_valid, req0_a, req0_b, req0_sel, rsp0_ready,
        output req1_valid, req1_a, req1_b, req1_sel, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data
    );
endinterface

// File: rtl/alu_sched.sv
// Shares one ALU between two requesters (round-robin or port-0 priority).
// Latency: accept at edge N, result valid after edge N+1; one op per 3 cycles at best.
// Backpressure: result held in RESP until rsp_ready; no request accepted outside IDLE.
module alu_sched #(
    parameter bit FAIR = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_sched_if.slave   bus,
    output logic         busy,
    output logic         grant_id
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_sel;
    logic        rsp0_valid_q;
    logic        rsp1_valid_q;
    logic [31:0] rsp0_data_q;
    logic [31:0] rsp1_data_q;
    logic        win1;
    logic        rdy0;
    logic        rdy1;
    logic [31:0] alu_out;

    // Arbitration: port 1 wins when alone, or when contested and port 0 had the last grant
    always_comb begin
        win1 = 1'b0;
        if (FAIR) begin
            win1 = bus.req1_valid && (!bus.req0_valid || !grant_id);
        end else begin
            win1 = bus.req1_valid && !bus.req0_valid;
        end
    end

    // Ready only in IDLE, only to the winner, and never while reset is asserted
    assign rdy0 = rst_n && (state == IDLE) && bus.req0_valid && !win1;
    assign rdy1 = rst_n && (state == IDLE) && win1;

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_data  = rsp0_data_q;
    assign bus.rsp1_data  = rsp1_data_q;

    // Shared ALU driven from the latched operands; shifts use the low five bits of B
    always_comb begin
        alu_out = 32'h0;
        case (op_sel)
            ALU_ADD:  alu_out = op_a + op_b;
            ALU_SUB:  alu_out = op_a - op_b;
            ALU_AND:  alu_out = op_a & op_b;
            ALU_OR:   alu_out = op_a | op_b;
            ALU_XOR:  alu_out = op_a ^ op_b;
            ALU_SLL:  alu_out = op_a << op_b[4:0];
            ALU_SRL:  alu_out = op_a >> op_b[4:0];
            ALU_SRA:  alu_out = 32'($signed(op_a) >>> op_b[4:0]);
            ALU_SLT:  alu_out = {31'h0, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_out = {31'h0, (op_a < op_b)};
            default:  alu_out = 32'h0;
        endcase
    end

    // Scheduler FSM: accept in IDLE, compute in EXEC, hold the result in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            op_a         <= 32'h0;
            op_b         <= 32'h0;
            op_sel       <= 4'h0;
            grant_id     <= 1'b1;
            busy         <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= 32'h0;
            rsp1_data_q  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (rdy0 || rdy1) begin
                        op_a     <= rdy1 ? bus.req1_a   : bus.req0_a;
                        op_b     <= rdy1 ? bus.req1_b   : bus.req0_b;
                        op_sel   <= rdy1 ? bus.req1_sel : bus.req0_sel;
                        grant_id <= rdy1;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (grant_id) begin
                        rsp1_data_q  <= alu_out;
                        rsp1_valid_q <= 1'b1;
                    end else begin
                        rsp0_data_q  <= alu_out;
                        rsp0_valid_q <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (grant_id ? bus.rsp1_ready : bus.rsp0_ready) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
